// File: rtl/bp_pkg.sv
// Shared types and geometry for the dynamic branch predictor.
// The table geometry is set here once. The entry struct is sized from it,
// so every module that imports this package agrees on the layout.
package bp_pkg;

    localparam int BP_ENTRIES = 32;
    localparam int BP_PC_W    = 32;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = BP_PC_W - 2 - BP_IDX_W;

    // Instruction opcodes that count as control flow for the EX stage.
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bp_ctr_e;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
        bp_ctr_e             ctr;
    } bp_entry_t;

    // Saturating increment of a 2-bit confidence counter.
    function automatic bp_ctr_e ctr_inc(input bp_ctr_e c);
        return (c == CTR_ST) ? CTR_ST : bp_ctr_e'(c + 2'd1);
    endfunction

    // Saturating decrement of a 2-bit confidence counter.
    function automatic bp_ctr_e ctr_dec(input bp_ctr_e c);
        return (c == CTR_SNT) ? CTR_SNT : bp_ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bp_table.sv
// BTB / counter storage: a flop array with combinational lookups for the
// fetch PC and the EX PC, and one synchronous write port.
// The clear input wipes every entry to invalid and weakly-not-taken.
// A write is visible to the lookups only from the next cycle, so a fetch
// of the index being updated sees the old contents.
module bp_table
    import bp_pkg::*;
(
    input  logic                clk,
    input  logic                clear,
    input  logic [BP_IDX_W-1:0] fetch_idx,
    output bp_entry_t           fetch_entry,
    input  logic [BP_IDX_W-1:0] resolve_idx,
    output bp_entry_t           resolve_entry,
    input  logic                wr_en,
    input  logic [BP_IDX_W-1:0] wr_idx,
    input  bp_entry_t           wr_entry
);

    localparam bp_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

    bp_entry_t mem [BP_ENTRIES];

    assign fetch_entry   = mem[fetch_idx];
    assign resolve_entry = mem[resolve_idx];

    // Clear takes priority over any update issued in the same cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                mem[i] <= RESET_ENTRY;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit counters.
// IF gets a zero-latency prediction. The prediction rides through D and E
// in shadow registers that follow the hazard unit's stall and flush signals.
// EX checks it against the resolved outcome and trains the table.
module branch_predictor
    import bp_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [BP_PC_W-1:0]  i_pc_f,
    input  logic                i_stall_f,
    input  logic                i_stall_d,
    input  logic                i_flush_d,
    input  logic                i_flush_e,
    output logic                o_pred_taken_f,
    output logic [BP_PC_W-1:0]  o_pred_pc_f,
    input  logic                i_valid_e,
    input  logic                i_cf_e,
    input  logic [BP_PC_W-1:0]  i_pc_e,
    input  logic                i_taken_e,
    input  logic [BP_PC_W-1:0]  i_target_e,
    output logic                o_mispredict_e,
    output logic [BP_PC_W-1:0]  o_redirect_pc_e
);

    localparam int PC_W  = BP_PC_W;
    localparam int IDX_W = BP_IDX_W;
    localparam int TAG_W = BP_TAG_W;
    localparam logic [PC_W-1:0] PC_STEP = 4;

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    bp_entry_t        ent_f;
    bp_entry_t        ent_e;
    logic             hit_f;
    logic             hit_e;
    logic [PC_W-1:0]  pc_plus4_f;
    logic [PC_W-1:0]  pc_plus4_e;

    logic             pred_taken_d;
    logic [PC_W-1:0]  pred_pc_d;
    logic             pred_taken_e;
    logic [PC_W-1:0]  pred_pc_e;

    logic             wr_en;
    bp_entry_t        wr_entry;

    // IF stall only holds the fetch PC, which the hazard unit already owns.
    // The low PC bits are never part of index or tag.
    logic             unused_bits;
    assign unused_bits = ^{i_stall_f, i_pc_f[1:0], i_pc_e[1:0]};

    assign idx_f      = i_pc_f[IDX_W+1:2];
    assign tag_f      = i_pc_f[PC_W-1:IDX_W+2];
    assign idx_e      = i_pc_e[IDX_W+1:2];
    assign tag_e      = i_pc_e[PC_W-1:IDX_W+2];
    assign pc_plus4_f = i_pc_f + PC_STEP;
    assign pc_plus4_e = i_pc_e + PC_STEP;

    bp_table u_table (
        .clk           (i_clk),
        .clear         (i_reset),
        .fetch_idx     (idx_f),
        .fetch_entry   (ent_f),
        .resolve_idx   (idx_e),
        .resolve_entry (ent_e),
        .wr_en         (wr_en),
        .wr_idx        (idx_e),
        .wr_entry      (wr_entry)
    );

    assign hit_f          = ent_f.valid && (ent_f.tag == tag_f);
    assign hit_e          = ent_e.valid && (ent_e.tag == tag_e);
    assign o_pred_taken_f = hit_f && ent_f.ctr[1];
    assign o_pred_pc_f    = o_pred_taken_f ? ent_f.target : pc_plus4_f;

    // Shadow registers for D and E. Flush beats stall in D, and reset drops
    // every prediction still in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pred_taken_d <= 1'b0;
            pred_pc_d    <= '0;
            pred_taken_e <= 1'b0;
            pred_pc_e    <= '0;
        end else begin
            if (i_flush_d) begin
                pred_taken_d <= 1'b0;
                pred_pc_d    <= '0;
            end else if (!i_stall_d) begin
                pred_taken_d <= o_pred_taken_f;
                pred_pc_d    <= o_pred_pc_f;
            end
            if (i_flush_e) begin
                pred_taken_e <= 1'b0;
                pred_pc_e    <= '0;
            end else begin
                pred_taken_e <= pred_taken_d;
                pred_pc_e    <= pred_pc_d;
            end
        end
    end

    // Compare the carried prediction with the resolved outcome in EX.
    always_comb begin
        o_mispredict_e = 1'b0;
        if (i_valid_e && !i_reset) begin
            if (i_cf_e) begin
                if (pred_taken_e != i_taken_e) begin
                    o_mispredict_e = 1'b1;
                end else if (i_taken_e && pred_taken_e && (pred_pc_e != i_target_e)) begin
                    o_mispredict_e = 1'b1;
                end
            end else if (pred_taken_e) begin
                o_mispredict_e = 1'b1;
            end
        end
    end

    assign o_redirect_pc_e = (i_cf_e && i_taken_e) ? i_target_e : pc_plus4_e;

    // Table training from the resolved EX instruction.
    // A non-control-flow instruction that hits a taken entry invalidates that entry.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = ent_e;
        if (i_valid_e) begin
            if (i_cf_e) begin
                if (i_taken_e) begin
                    wr_en           = 1'b1;
                    wr_entry.valid  = 1'b1;
                    wr_entry.tag    = tag_e;
                    wr_entry.target = i_target_e;
                    wr_entry.ctr    = hit_e ? ctr_inc(ent_e.ctr) : CTR_WT;
                end else if (hit_e) begin
                    wr_en        = 1'b1;
                    wr_entry.ctr = ctr_dec(ent_e.ctr);
                end
            end else if (hit_e && ent_e.ctr[1]) begin
                wr_en          = 1'b1;
                wr_entry.valid = 1'b0;
                wr_entry.ctr   = CTR_WNT;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Inputs change just after the falling edge, and outputs are sampled 1 time
// unit later, well away from the rising edge.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] pcF;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        flushE;
    logic        predTakenF;
    logic [31:0] predPcF;
    logic        validE;
    logic        cfE;
    logic [31:0] pcE;
    logic        takenE;
    logic [31:0] targetE;
    logic        mispredictE;
    logic [31:0] redirectPcE;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IDLE_PC = 32'h0000_1004;

    branch_predictor dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_pc_f          (pcF),
        .i_stall_f       (stallF),
        .i_stall_d       (stallD),
        .i_flush_d       (flushD),
        .i_flush_e       (flushE),
        .o_pred_taken_f  (predTakenF),
        .o_pred_pc_f     (predPcF),
        .i_valid_e       (validE),
        .i_cf_e          (cfE),
        .i_pc_e          (pcE),
        .i_taken_e       (takenE),
        .i_target_e      (targetE),
        .o_mispredict_e  (mispredictE),
        .o_redirect_pc_e (redirectPcE)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] fetchPc, input logic valid, input logic cf,
                                 input logic [31:0] exPc, input logic taken, input logic [31:0] target);
        pcF     = fetchPc;
        validE  = valid;
        cfE     = cf;
        pcE     = exPc;
        takenE  = taken;
        targetE = target;
        #1;
    endtask

    // Fetch pc, let it travel through D, then resolve it in EX two cycles later.
    task automatic runBranch(input string tag, input logic [31:0] pc, input logic cf,
                             input logic taken, input logic [31:0] target,
                             input logic expTaken, input logic [31:0] expPc,
                             input logic expMis, input logic [31:0] expRedirect);
        applyStimulus(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput({tag, ".predTaken"}, {31'b0, predTakenF}, {31'b0, expTaken});
        checkOutput({tag, ".predPc"}, predPcF, expPc);
        tick();
        applyStimulus(IDLE_PC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(IDLE_PC, 1'b1, cf, pc, taken, target);
        checkOutput({tag, ".mispredict"}, {31'b0, mispredictE}, {31'b0, expMis});
        if (expMis) begin
            checkOutput({tag, ".redirect"}, redirectPcE, expRedirect);
        end
        tick();
        applyStimulus(IDLE_PC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        reset  = 1'b1;
        @(negedge clk);

        // Reset cycle with a taken branch already in EX: no redirect, no training.
        applyStimulus(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h1F0);
        checkOutput("resetMispredict", {31'b0, mispredictE}, 32'h0);
        tick();
        reset = 1'b0;
        applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("resetPredTaken", {31'b0, predTakenF}, 32'h0);
        checkOutput("resetPredPc", predPcF, 32'h104);
        checkOutput("resetIdleMispredict", {31'b0, mispredictE}, 32'h0);

        // Loop branch 0x200 -> 0x1F0 taken three times.
        runBranch("loop1", 32'h200, 1'b1, 1'b1, 32'h1F0, 1'b0, 32'h204, 1'b1, 32'h1F0);
        runBranch("loop2", 32'h200, 1'b1, 1'b1, 32'h1F0, 1'b1, 32'h1F0, 1'b0, 32'h0);
        runBranch("loop3", 32'h200, 1'b1, 1'b1, 32'h1F0, 1'b1, 32'h1F0, 1'b0, 32'h0);

        // Loop exit: counter 11 -> 10 -> 01 -> 00.
        runBranch("exit1", 32'h200, 1'b1, 1'b0, 32'h1F0, 1'b1, 32'h1F0, 1'b1, 32'h204);
        runBranch("exit2", 32'h200, 1'b1, 1'b0, 32'h1F0, 1'b1, 32'h1F0, 1'b1, 32'h204);
        runBranch("exit3", 32'h200, 1'b1, 1'b0, 32'h1F0, 1'b0, 32'h204, 1'b0, 32'h0);

        // JALR whose target moves from 0x400 to 0x500.
        runBranch("jalr1", 32'h300, 1'b1, 1'b1, 32'h400, 1'b0, 32'h304, 1'b1, 32'h400);
        runBranch("jalr2", 32'h300, 1'b1, 1'b1, 32'h500, 1'b1, 32'h400, 1'b1, 32'h500);
        runBranch("jalr3", 32'h300, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 32'h0);

        // Predicted-taken 0x300 held in D by stalls, then flush and stall together.
        applyStimulus(32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("stall.fetchTaken", {31'b0, predTakenF}, 32'h1);
        tick();
        stallD = 1'b1;
        flushE = 1'b1;
        applyStimulus(IDLE_PC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        flushE = 1'b0;
        applyStimulus(IDLE_PC, 1'b1, 1'b0, 32'h308, 1'b0, 32'h0);
        checkOutput("stall.emptyE", {31'b0, mispredictE}, 32'h0);
        tick();
        flushD = 1'b1;
        flushE = 1'b1;
        applyStimulus(IDLE_PC, 1'b1, 1'b0, 32'h308, 1'b0, 32'h0);
        checkOutput("stall.heldPred", {31'b0, mispredictE}, 32'h1);
        checkOutput("stall.heldRedirect", redirectPcE, 32'h30C);
        tick();
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        applyStimulus(IDLE_PC, 1'b1, 1'b0, 32'h308, 1'b0, 32'h0);
        checkOutput("stall.afterFlush1", {31'b0, mispredictE}, 32'h0);
        tick();
        applyStimulus(IDLE_PC, 1'b1, 1'b0, 32'h308, 1'b0, 32'h0);
        checkOutput("stall.afterFlush2", {31'b0, mispredictE}, 32'h0);
        tick();

        // 0x80 and 0x100 share index 0; the later allocation evicts the first.
        runBranch("alias80a", 32'h80, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h84, 1'b1, 32'h1000);
        runBranch("alias80b", 32'h80, 1'b1, 1'b1, 32'h1000, 1'b1, 32'h1000, 1'b0, 32'h0);
        runBranch("alias100", 32'h100, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h104, 1'b1, 32'h2000);
        runBranch("alias80c", 32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 32'h84, 1'b0, 32'h0);

        // Non-control-flow instruction hitting a taken entry: redirect and invalidate.
        runBranch("stale1", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b1, 32'h104);
        runBranch("stale2", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h0);

        // Same-index fetch during an allocation sees the old contents.
        applyStimulus(32'h184, 1'b1, 1'b1, 32'h184, 1'b1, 32'h3000);
        checkOutput("bypass.predTaken", {31'b0, predTakenF}, 32'h0);
        checkOutput("bypass.predPc", predPcF, 32'h188);
        checkOutput("bypass.mispredict", {31'b0, mispredictE}, 32'h1);
        checkOutput("bypass.redirect", redirectPcE, 32'h3000);
        tick();
        applyStimulus(32'h184, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("bypass.afterTaken", {31'b0, predTakenF}, 32'h1);
        checkOutput("bypass.afterPc", predPcF, 32'h3000);

        // PC+4 wraps modulo 2^32.
        applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("wrap.predPc", predPcF, 32'h0);

        // Mid-operation reset with a taken prediction in flight.
        applyStimulus(32'h184, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        applyStimulus(IDLE_PC, 1'b1, 1'b1, 32'h184, 1'b1, 32'h3000);
        checkOutput("midReset.mispredict", {31'b0, mispredictE}, 32'h0);
        tick();
        reset = 1'b0;
        applyStimulus(32'h184, 1'b1, 1'b0, 32'h400, 1'b0, 32'h0);
        checkOutput("midReset.predTaken", {31'b0, predTakenF}, 32'h0);
        checkOutput("midReset.predPc", predPcF, 32'h188);
        checkOutput("midReset.noRedirect", {31'b0, mispredictE}, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
